food_map_ctrl: RTL and testbench
================================

FOOD_MAP_CTRL -- requirements
Module: food_map_ctrl

Interface
REQ-001 SHALL have parameters: ROWS, default 64, food-map rows; COLS, default 80, bits per row; ADDR_W, default 6, row address width.
REQ-002 SHALL have these ports (name, direction, width, meaning):
- clk  in  1  sole clock.
- rst  in  1  reset; synchronous, active-high.
- render_en  in  1  renderer row read request.
- render_row  in  ADDR_W  renderer row address.
- render_data  out  COLS  row data.
- render_valid  out  1  render_data valid.
- eat_req  in  1  pacman eat request; held until eat_ack.
- eat_x  in  7  column index.
- eat_y  in  ADDR_W  row index.
- eat_ack  out  1  one-cycle completion pulse.
- eat_hit  out  1  food was present; valid with eat_ack.
- refill_start  in  1  pulse; reload map from ROM.
- busy  out  1  refill in progress.
- rom_addr  out  ADDR_W  pristine-map ROM address.
- rom_data  in  COLS  ROM data; 1-cycle latency.
- bram_en  out  1  food_map BRAM enable.
- bram_we  out  1  food_map BRAM write enable.
- bram_addr  out  ADDR_W  food_map BRAM address.
- bram_din  out  COLS  food_map BRAM write data.
- bram_dout  in  COLS  food_map BRAM read data; 1-cycle latency.
- food_left  out  13  remaining pellets.
- level_clear  out  1  one-cycle pulse.

Function
REQ-003 SHALL arbitrate the single-port food_map BRAM between the renderer, the eat read-modify-write and refill, with the renderer at absolute priority: when render_en=1, bram_addr=render_row, bram_we=0, and the FSM stalls any BRAM access of its own.
REQ-004 SHALL assert render_valid exactly 1 cycle after render_en, with render_data equal to bram_dout.
REQ-005 SHALL implement states IDLE, EAT_RD, EAT_WAIT, EAT_WR, REFILL.
REQ-006 SHALL, in IDLE, take refill_start (or a latched pending refill) over eat_req when both are present.
REQ-007 SHALL perform the eat sequence as follows:
- EAT_RD issues a read of eat_y, holding while render_en=1.
- EAT_WAIT captures bram_dout unconditionally.
- EAT_WR writes the row back with bit eat_x cleared, holding while render_en=1.
- eat_ack and eat_hit are registered and asserted the cycle after EAT_WR completes.
REQ-008 SHALL, if the captured bit is 0, skip the write and ack with eat_hit=0 one cycle after EAT_WAIT.
REQ-009 SHALL, if eat_x>=COLS, ack with eat_hit=0 the cycle after the request is sampled in IDLE, with no BRAM access.
REQ-010 SHALL, with render_en low, assert eat_ack 4 cycles after eat_req is sampled in IDLE.
REQ-011 SHALL decrement food_left on each hit, saturating at 0.
REQ-012 SHALL pulse level_clear for 1 cycle when food_left transitions from 1 to 0.
REQ-013 SHALL latch a refill_start that arrives during an eat sequence, and begin the refill after eat_ack.
REQ-014 SHALL perform REFILL as a pipelined row sweep:
- Row r is read from the ROM; its rom_data is written to BRAM row r the next cycle.
- Rows 0..ROWS-1 are swept in order.
- render_en stalls the write, with rom_data held in a register.
- Unstalled, the sweep completes in ROWS+1 cycles.
REQ-015 SHALL accumulate the popcount of each written row, and load food_left with the total the cycle after the last write.
REQ-016 SHALL hold busy high throughout REFILL.
REQ-017 SHALL ignore refill_start while busy.
REQ-018 SHALL not pulse level_clear if a refill loads a total of 0.

Reset
REQ-019 SHALL, on rst, place the FSM in IDLE and clear the pending refill flag.
REQ-020 SHALL drive these values on reset: food_left=0, eat_ack=0, eat_hit=0, level_clear=0, busy=0, render_valid=0, bram_en=0, bram_we=0.
REQ-021 SHALL abort a refill or eat in progress on rst, leaving BRAM contents unmodified by reset itself.

Configuration
REQ-022 SHALL, with FOOD_SCORE_EN defined, add output score (16 bits), reset to 0, incremented by 10 per hit, saturating at 16'hFFFF, and cleared on refill_start.
REQ-023 SHALL, without FOOD_SCORE_EN, omit the score port and its logic.

Structure
REQ-024 SHALL place ROWS/COLS/ADDR_W defaults, the FSM state encoding and the pellet score constant (10) in the shared package food_map_pkg.
REQ-025 SHALL implement the COLS-bit combinational popcount as sub-module food_popcount.

Verification
REQ-026 SHALL cover these directed scenarios:
- Refill with a ROM holding 3 ones per row, render_en=0 -> busy for 65 cycles, food_left=192.
- Eat at (5,2) with the bit set, render_en=0 -> eat_ack at +4 cycles, eat_hit=1, row 2 bit 5 reads 0, food_left=191.
- Repeat the same eat -> eat_hit=0, no bram_we, food_left unchanged.
- Eat with render_en=1 for 3 cycles during EAT_WR -> write delayed 3 cycles; render_valid/render_data are correct every cycle.
- Map with 1 pellet; eat it -> food_left=0 with a single level_clear pulse.
- refill_start and eat_req in the same IDLE cycle -> refill runs first, eat acked after refill; rst at refill row 30 -> busy=0, food_left=0 next cycle.

Source files
------------

// File: rtl/food_map_pkg.sv
// food_map_pkg -- shared constants and types for the food-map controller.
//   ROWS_DEF / COLS_DEF / ADDR_W_DEF : default map geometry
//   FOOD_W                           : width of the pellet counter
//   PELLET_SCORE                     : score awarded per pellet eaten
//   state_t                          : controller FSM encoding
package food_map_pkg;

  localparam int ROWS_DEF   = 64;
  localparam int COLS_DEF   = 80;
  localparam int ADDR_W_DEF = 6;
  localparam int FOOD_W     = 13;

  localparam logic [15:0] PELLET_SCORE = 16'd10;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    EAT_RD   = 3'd1,
    EAT_WAIT = 3'd2,
    EAT_WR   = 3'd3,
    REFILL   = 3'd4
  } state_t;

endpackage

// File: rtl/food_map_if.sv
// food_map_if -- memory-side bus of the food-map controller.
//   food_map BRAM : bram_en, bram_we, bram_addr, bram_din -> memory;
//                   bram_dout <- memory (1-cycle read latency)
//   pristine ROM  : rom_addr -> ROM; rom_data <- ROM (1-cycle latency)
//   master modport: the controller; slave modport: the memories.
interface food_map_if #(
  parameter int ADDR_W = food_map_pkg::ADDR_W_DEF,
  parameter int COLS   = food_map_pkg::COLS_DEF
) ();

  logic              bram_en;
  logic              bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [COLS-1:0]   bram_din;
  logic [COLS-1:0]   bram_dout;
  logic [ADDR_W-1:0] rom_addr;
  logic [COLS-1:0]   rom_data;

  modport master (
    output bram_en, bram_we, bram_addr, bram_din, rom_addr,
    input  bram_dout, rom_data
  );

  modport slave (
    input  bram_en, bram_we, bram_addr, bram_din, rom_addr,
    output bram_dout, rom_data
  );

endinterface

// File: rtl/food_popcount.sv
// food_popcount -- combinational population count of one food-map row.
//   bits  : COLS-bit row
//   count : number of set bits
module food_popcount
  import food_map_pkg::*;
#(
  parameter int COLS = COLS_DEF
) (
  input  logic [COLS-1:0]   bits,
  output logic [FOOD_W-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < COLS; i++) begin
      count = count + FOOD_W'(bits[i]);
    end
  end

endmodule

// File: rtl/food_map_ctrl.sv
// food_map_ctrl -- owns the single-port food_map BRAM shared by the
// renderer, pacman's eat read-modify-write and the level refill.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   render_en/row     : renderer row read; always wins the BRAM
//   render_data/valid : row data, valid one cycle after render_en
//   eat_req/x/y       : eat request at (column x, row y)
//   eat_ack/eat_hit   : one-cycle completion pulse, hit flag with it
//   refill_start      : pulse, reload the map from the pristine ROM
//   busy              : refill in progress
//   mem               : food_map_if master (BRAM + ROM bus)
//   food_left         : remaining pellets
//   level_clear       : pulse when the last pellet is eaten
//   score             : (only with FOOD_SCORE_EN) running score
//   state_dbg         : current FSM state
//
// Eat handshake: the requester raises eat_req with eat_x/eat_y stable and
// holds all three until it sees eat_ack high; eat_hit is meaningful only
// while eat_ack is high. A request is never accepted in the cycle eat_ack
// is high, so a requester that drops eat_req on seeing the ack is not
// served twice.
//
// Optional feature: define FOOD_SCORE_EN to add the 16-bit score output.
module food_map_ctrl
  import food_map_pkg::*;
#(
  parameter int ROWS   = ROWS_DEF,
  parameter int COLS   = COLS_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              render_en,
  input  logic [ADDR_W-1:0] render_row,
  output logic [COLS-1:0]   render_data,
  output logic              render_valid,
  input  logic              eat_req,
  input  logic [6:0]        eat_x,
  input  logic [ADDR_W-1:0] eat_y,
  output logic              eat_ack,
  output logic              eat_hit,
  input  logic              refill_start,
  output logic              busy,
  food_map_if.master        mem,
  output logic [FOOD_W-1:0] food_left,
  output logic              level_clear,
`ifdef FOOD_SCORE_EN
  output logic [15:0]       score,
`endif
  output state_t            state_dbg
);

  // Row counter must reach ROWS itself, hence one extra bit.
  localparam int CNT_W = ADDR_W + 1;

  state_t              state;
  state_t              state_nxt;
  logic                pend_q;
  logic [6:0]          x_q;
  logic [ADDR_W-1:0]   y_q;
  logic [COLS-1:0]     row_q;
  logic                ack_nxt;
  logic                hit_nxt;
  logic                eat_go;
  logic                x_oob;
  logic [COLS-1:0]     clr_mask;

  // Refill pipeline: stage 1 reads ROM row rd_idx, stage 2 writes wr_idx.
  logic [CNT_W-1:0]    rd_idx;
  logic                wr_vld;
  logic [ADDR_W-1:0]   wr_idx;
  logic [COLS-1:0]     hold_q;
  logic                hold_vld;
  logic [COLS-1:0]     wr_data;
  logic                fill_wr;
  logic                fill_rd;
  logic                fill_done;
  logic [FOOD_W-1:0]   acc_q;
  logic [FOOD_W-1:0]   row_cnt;

  food_popcount #(.COLS(COLS)) u_popcount (
    .bits  (wr_data),
    .count (row_cnt)
  );

  assign busy        = (state == REFILL);
  assign state_dbg   = state;
  assign render_data = mem.bram_dout;

  always_comb begin
    eat_go   = eat_req && !eat_ack;
    x_oob    = ({25'd0, eat_x} >= 32'(COLS));
    clr_mask = ~({{(COLS-1){1'b0}}, 1'b1} << x_q);
    // While a write is stalled the ROM has moved on; use the held copy.
    wr_data   = hold_vld ? hold_q : mem.rom_data;
    fill_wr   = (state == REFILL) && wr_vld && !render_en;
    fill_rd   = (state == REFILL) && (!wr_vld || fill_wr) && (rd_idx < CNT_W'(ROWS));
    fill_done = fill_wr && (rd_idx == CNT_W'(ROWS));
  end

  // Next-state and ack decode.
  always_comb begin
    state_nxt = state;
    ack_nxt   = 1'b0;
    hit_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (refill_start || pend_q) begin
          state_nxt = REFILL;
        end else if (eat_go) begin
          if (x_oob) ack_nxt = 1'b1;
          else       state_nxt = EAT_RD;
        end
      end
      EAT_RD: begin
        if (!render_en) state_nxt = EAT_WAIT;
      end
      EAT_WAIT: begin
        if (mem.bram_dout[x_q]) begin
          state_nxt = EAT_WR;
        end else begin
          state_nxt = IDLE;
          ack_nxt   = 1'b1;
        end
      end
      EAT_WR: begin
        if (!render_en) begin
          state_nxt = IDLE;
          ack_nxt   = 1'b1;
          hit_nxt   = 1'b1;
        end
      end
      REFILL: begin
        if (fill_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // BRAM port mux. The renderer overrides everything; rst gates the port
  // so an access in flight is dropped rather than committed.
  always_comb begin
    mem.bram_en   = 1'b0;
    mem.bram_we   = 1'b0;
    mem.bram_addr = render_row;
    mem.bram_din  = '0;
    mem.rom_addr  = rd_idx[ADDR_W-1:0];
    if (rst) begin
      mem.bram_en = 1'b0;
    end else if (render_en) begin
      mem.bram_en   = 1'b1;
      mem.bram_addr = render_row;
    end else begin
      case (state)
        EAT_RD: begin
          mem.bram_en   = 1'b1;
          mem.bram_addr = y_q;
        end
        EAT_WR: begin
          mem.bram_en   = 1'b1;
          mem.bram_we   = 1'b1;
          mem.bram_addr = y_q;
          mem.bram_din  = row_q & clr_mask;
        end
        REFILL: begin
          if (wr_vld) begin
            mem.bram_en   = 1'b1;
            mem.bram_we   = 1'b1;
            mem.bram_addr = wr_idx;
            mem.bram_din  = wr_data;
          end
        end
        default: mem.bram_en = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      pend_q       <= 1'b0;
      eat_ack      <= 1'b0;
      eat_hit      <= 1'b0;
      level_clear  <= 1'b0;
      food_left    <= '0;
      render_valid <= 1'b0;
      rd_idx       <= '0;
      wr_vld       <= 1'b0;
      hold_vld     <= 1'b0;
      acc_q        <= '0;
    end else begin
      state        <= state_nxt;
      render_valid <= render_en;
      eat_ack      <= ack_nxt;
      eat_hit      <= hit_nxt;
      level_clear  <= 1'b0;

      // A refill requested mid-eat waits here until the eat is acked.
      if (state == IDLE) begin
        pend_q <= 1'b0;
      end else if (state != REFILL && refill_start) begin
        pend_q <= 1'b1;
      end

      if (state == IDLE && eat_go) begin
        x_q <= eat_x;
        y_q <= eat_y;
      end

      if (state == EAT_WAIT) row_q <= mem.bram_dout;

      if (hit_nxt) begin
        if (food_left != '0) food_left <= food_left - FOOD_W'(1);
        level_clear <= (food_left == FOOD_W'(1));
      end

      if (state == IDLE && state_nxt == REFILL) begin
        rd_idx   <= '0;
        wr_vld   <= 1'b0;
        hold_vld <= 1'b0;
        acc_q    <= '0;
      end else if (state == REFILL) begin
        if (fill_wr) acc_q <= acc_q + row_cnt;
        if (fill_rd) begin
          wr_vld   <= 1'b1;
          wr_idx   <= rd_idx[ADDR_W-1:0];
          rd_idx   <= rd_idx + CNT_W'(1);
          hold_vld <= 1'b0;
        end else if (fill_wr) begin
          wr_vld <= 1'b0;
        end else if (wr_vld && !hold_vld) begin
          // First stalled cycle: rom_data still belongs to wr_idx.
          hold_q   <= mem.rom_data;
          hold_vld <= 1'b1;
        end
        if (fill_done) food_left <= acc_q + row_cnt;
      end
    end
  end

`ifdef FOOD_SCORE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      score <= '0;
    end else if (refill_start && state != REFILL) begin
      score <= '0;
    end else if (hit_nxt) begin
      score <= (score > 16'hFFFF - PELLET_SCORE) ? 16'hFFFF : score + PELLET_SCORE;
    end
  end
`endif

endmodule

// File: tb/tb_food_map_ctrl.sv
// tb_food_map_ctrl -- bench for food_map_ctrl with behavioural BRAM and ROM.
module tb_food_map_ctrl;
  import food_map_pkg::*;

  localparam int ROWS   = ROWS_DEF;
  localparam int COLS   = COLS_DEF;
  localparam int ADDR_W = ADDR_W_DEF;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              render_en = 1'b0;
  logic [ADDR_W-1:0] render_row = '0;
  logic [COLS-1:0]   render_data;
  logic              render_valid;
  logic              eat_req = 1'b0;
  logic [6:0]        eat_x = '0;
  logic [ADDR_W-1:0] eat_y = '0;
  logic              eat_ack;
  logic              eat_hit;
  logic              refill_start = 1'b0;
  logic              busy;
  logic [FOOD_W-1:0] food_left;
  logic              level_clear;
  state_t            state_dbg;
`ifdef FOOD_SCORE_EN
  logic [15:0]       score;
`endif

  food_map_if #(.ADDR_W(ADDR_W), .COLS(COLS)) mif ();

  food_map_ctrl #(.ROWS(ROWS), .COLS(COLS), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .render_en    (render_en),
    .render_row   (render_row),
    .render_data  (render_data),
    .render_valid (render_valid),
    .eat_req      (eat_req),
    .eat_x        (eat_x),
    .eat_y        (eat_y),
    .eat_ack      (eat_ack),
    .eat_hit      (eat_hit),
    .refill_start (refill_start),
    .busy         (busy),
    .mem          (mif),
    .food_left    (food_left),
    .level_clear  (level_clear),
`ifdef FOOD_SCORE_EN
    .score        (score),
`endif
    .state_dbg    (state_dbg)
  );

  // ---------------- memory models ----------------
  logic [COLS-1:0] bram [ROWS];
  logic [COLS-1:0] rom  [ROWS];

  always @(posedge clk) begin
    if (mif.bram_en) begin
      if (mif.bram_we) bram[mif.bram_addr] <= mif.bram_din;
      mif.bram_dout <= bram[mif.bram_addr];
    end
    mif.rom_data <= rom[mif.rom_addr];
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [COLS-1:0] exp_q[$];       // expected render rows
  logic [0:0]      exp_hit_q[$];   // expected eat_hit per ack
  logic [COLS-1:0] exp_map [ROWS];
  int exp_food = 0;
  int we_cnt = 0;
  int lc_cnt = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  logic [COLS-1:0] mon_row;
  logic [0:0]      mon_hit;
  always @(negedge clk) begin
    if (!rst) begin
      if (render_valid) begin
        if (exp_q.size() == 0) check("render_unexpected", 1, 0);
        else begin
          mon_row = exp_q.pop_front();
          check("render_data", render_data, mon_row);
        end
      end
      if (eat_ack) begin
        if (exp_hit_q.size() == 0) check("ack_unexpected", 1, 0);
        else begin
          mon_hit = exp_hit_q.pop_front();
          check("eat_hit", eat_hit, mon_hit);
        end
      end
      if (mif.bram_we) we_cnt++;
      if (level_clear) lc_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_rom(input int mode);
    for (int r = 0; r < ROWS; r++) begin
      rom[r] = '0;
      if (mode == 0) begin
        rom[r][5]           = 1'b1;
        rom[r][20 + r % 20] = 1'b1;
        rom[r][79 - r % 10] = 1'b1;
      end
    end
    if (mode == 1) rom[9][3] = 1'b1;
  endtask

  task automatic load_model();
    exp_food = 0;
    for (int r = 0; r < ROWS; r++) begin
      exp_map[r] = rom[r];
      exp_food += $countones(rom[r]);
    end
  endtask

  task automatic wait_refill();
    int n;
    n = 0;
    while (busy && n < 300) begin
      n++;
      @(negedge clk);
    end
    check("refill_busy_cycles", n, ROWS + 1);
    load_model();
    check("food_after_refill", food_left, exp_food);
  endtask

  task automatic do_refill();
    refill_start = 1'b1;
    @(negedge clk);
    refill_start = 1'b0;
    wait_refill();
  endtask

  task automatic do_render(input int row);
    render_en  = 1'b1;
    render_row = ADDR_W'(row);
    exp_q.push_back(exp_map[row]);
    @(negedge clk);
    render_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_eat(input int x, input int y, input int stall_at, input int stall_len,
                        input int refill_at, input int exp_lat);
    logic hit;
    int   n;
    int   row;
    logic got;
    hit = 1'b0;
    if (x < COLS) hit = exp_map[y][x];
    exp_hit_q.push_back(hit);
    eat_x   = 7'(x);
    eat_y   = ADDR_W'(y);
    eat_req = 1'b1;
    n   = 0;
    got = 1'b0;
    while (!got && n < 200) begin
      refill_start = (n == refill_at);
      if (n >= stall_at && n < stall_at + stall_len) begin
        row        = (y + n) % ROWS;
        render_en  = 1'b1;
        render_row = ADDR_W'(row);
        exp_q.push_back(exp_map[row]);
      end else begin
        render_en = 1'b0;
      end
      @(negedge clk);
      n++;
      got = eat_ack;
    end
    render_en    = 1'b0;
    refill_start = 1'b0;
    eat_req      = 1'b0;
    check("eat_ack_seen", got, 1);
    check("eat_latency", n, exp_lat);
    if (hit) begin
      exp_map[y][x] = 1'b0;
      if (exp_food > 0) exp_food--;
    end
    check("food_left", food_left, exp_food);
    @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int base;
    int x;
    int y;
    int lat;
    for (int r = 0; r < ROWS; r++) begin
      bram[r]    = '0;
      exp_map[r] = '0;
    end
    set_rom(0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_food_left", food_left, 0);
    check("rst_busy", busy, 0);
    check("rst_eat_ack", eat_ack, 0);
    check("rst_eat_hit", eat_hit, 0);
    check("rst_level_clear", level_clear, 0);
    check("rst_render_valid", render_valid, 0);
    check("rst_bram_en", mif.bram_en, 0);
    check("rst_bram_we", mif.bram_we, 0);
    rst = 1'b0;
    @(negedge clk);

    // Full refill, 3 pellets per row.
    do_refill();
    check("food_192", food_left, 192);
    do_render(2);
    do_render(63);

    // Eat hit, then the same eat again as a miss with no write.
    do_eat(5, 2, 0, 0, -1, 4);
    check("food_191", food_left, 191);
    do_render(2);
    base = we_cnt;
    do_eat(5, 2, 0, 0, -1, 3);
    check("miss_no_write", we_cnt, base);

    // Renderer steals the port for 3 cycles during EAT_WR.
    do_eat(24, 4, 3, 3, -1, 7);
    do_render(4);

    // Column boundaries.
    do_eat(79, 10, 0, 0, -1, 4);
    base = we_cnt;
    do_eat(80, 10, 0, 0, -1, 1);
    do_eat(127, 0, 0, 0, -1, 1);
    check("oob_no_write", we_cnt, base);

    // Random eats interleaved with renders.
    repeat (10) begin
      x = $urandom_range(0, 85);
      y = $urandom_range(0, ROWS - 1);
      if (x >= COLS)           lat = 1;
      else if (exp_map[y][x])  lat = 4;
      else                     lat = 3;
      do_eat(x, y, 0, 0, -1, lat);
      do_render($urandom_range(0, ROWS - 1));
    end

    // refill_start during an eat is deferred until after the ack.
    do_eat(5, 7, 0, 0, 1, 4);
    check("pending_refill_busy", busy, 1);
    wait_refill();

    // Single pellet: eating it clears the level once.
    set_rom(1);
    do_refill();
    base = lc_cnt;
    do_eat(3, 9, 0, 0, -1, 4);
    repeat (3) @(negedge clk);
    check("level_clear_once", lc_cnt, base + 1);
    do_eat(3, 9, 0, 0, -1, 3);
    check("food_stays_0", food_left, 0);

    // Refill loading zero pellets raises no level_clear.
    set_rom(2);
    base = lc_cnt;
    do_refill();
    check("no_clear_on_empty_refill", lc_cnt, base);

    // refill_start and eat_req together: refill first, eat after.
    set_rom(0);
    load_model();
    do_eat(5, 2, 0, 0, 0, ROWS + 6);

    // Reset during the refill sweep.
    refill_start = 1'b1;
    @(negedge clk);
    refill_start = 1'b0;
    repeat (30) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_refill_busy", busy, 0);
    check("rst_mid_refill_food", food_left, 0);
    rst = 1'b0;
    @(negedge clk);

    do_refill();
    do_render(30);
    do_render(31);

    repeat (3) @(negedge clk);
    check("render_queue_empty", exp_q.size(), 0);
    check("ack_queue_empty", exp_hit_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
